scalar_wb_arbiter: RTL and testbench

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

---
 rtl/scalar_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_arbiter.sv
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
// Scalar write-back arbiter (ALU/LSU/V2S) with pending-register scoreboard; write port registered, 1-cycle latency.
// Arbitration: round-robin when WB_ARB_ROUND_ROBIN_EN is defined, else fixed LSU > V2S > ALU.
module scalar_wb_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [2:0]                 src_valid_i,
  output logic [2:0]                 src_ready_o,
  input  logic [2:0][4:0]            src_rd_i,
  input  logic [2:0][DATA_WIDTH-1:0] src_data_i,
  input  logic                       wb_stall_i,
  output logic                       rf_wr_en_o,
  output logic [4:0]                 rf_wr_addr_o,
  output logic [DATA_WIDTH-1:0]      rf_wr_data_o,
  input  logic                       alloc_valid_i,
  input  logic [4:0]                 alloc_rd_i,
  input  logic [4:0]                 query_rs1_i,
  input  logic [4:0]                 query_rs2_i,
  output logic                       rs1_busy_o,
  output logic                       rs2_busy_o,
  output logic                       idle_o
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_V2S = 2'd2;

  logic [2:0]            grant;
  logic [1:0]            gidx;
  logic                  hs;
  logic [4:0]            hs_rd;
  logic [DATA_WIDTH-1:0] hs_data;

  logic [1:0]            last_grant_q, last_grant_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [4:0]            rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_V2S) ? SRC_ALU : s + 2'd1;
  endfunction

  logic [1:0] prio0, prio1, prio2;
  assign prio0 = next_src(last_grant_q);
  assign prio1 = next_src(prio0);
  assign prio2 = next_src(prio1);
`endif

  // Grant looks only at valids, stall and arbiter state so ready never depends on rd/data.
  always_comb begin
    grant = '0;
    if (reset_n_i && !wb_stall_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (src_valid_i[prio0])      grant[prio0] = 1'b1;
      else if (src_valid_i[prio1]) grant[prio1] = 1'b1;
      else if (src_valid_i[prio2]) grant[prio2] = 1'b1;
`else
      if (src_valid_i[SRC_LSU])      grant[SRC_LSU] = 1'b1;
      else if (src_valid_i[SRC_V2S]) grant[SRC_V2S] = 1'b1;
      else if (src_valid_i[SRC_ALU]) grant[SRC_ALU] = 1'b1;
`endif
    end
  end

  always_comb begin
    gidx = SRC_ALU;
    if (grant[SRC_LSU])      gidx = SRC_LSU;
    else if (grant[SRC_V2S]) gidx = SRC_V2S;
  end

  assign hs      = |grant;
  assign hs_rd   = src_rd_i[gidx];
  assign hs_data = src_data_i[gidx];

  always_comb begin
    rf_wr_en_d   = hs && (hs_rd != 5'd0);
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    if (hs) begin
      last_grant_d  = gidx;
      busy_d[hs_rd] = 1'b0;
    end
    if (rf_wr_en_d) begin
      rf_wr_addr_d = hs_rd;
      rf_wr_data_d = hs_data;
    end
    // A fresh allocation on the write-back edge must survive the clear.
    if (alloc_valid_i && (alloc_rd_i != 5'd0)) busy_d[alloc_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      last_grant_q <= SRC_V2S;
      busy_q       <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign src_ready_o  = grant;
  assign rf_wr_en_o   = rf_wr_en_q;
  assign rf_wr_addr_o = rf_wr_addr_q;
  assign rf_wr_data_o = rf_wr_data_q;
  assign rs1_busy_o   = busy_q[query_rs1_i];
  assign rs2_busy_o   = busy_q[query_rs2_i];
  assign idle_o       = ~(|busy_q) && !rf_wr_en_q;

  // Sources waiting for a grant must keep their request stable.
  for (genvar i = 0; i < 3; i++) begin : g_hold_chk
    a_src_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (src_valid_i[i] && !src_ready_o[i]) |=>
        (src_valid_i[i] && $stable(src_rd_i[i]) && $stable(src_data_i[i])));
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
`timescale 1ns/1ps
// Bench for scalar_wb_arbiter: directed scenarios, then constrained-random traffic against a rule-level model.
module tb_scalar_wb_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       src_valid;
  logic [2:0]       src_ready;
  logic [2:0][4:0]  src_rd;
  logic [2:0][31:0] src_data;
  logic             wb_stall;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_addr;
  logic [31:0]      rf_wr_data;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic [4:0]       query_rs1, query_rs2;
  logic             rs1_busy, rs2_busy;
  logic             idle;

  int checks = 0;
  int errors = 0;

  bit          m_busy [32];
  int          m_last;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [2:0]  last_g;

  always #5 clk = ~clk;

  scalar_wb_arbiter #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .src_valid_i  (src_valid),
    .src_ready_o  (src_ready),
    .src_rd_i     (src_rd),
    .src_data_i   (src_data),
    .wb_stall_i   (wb_stall),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_addr_o (rf_wr_addr),
    .rf_wr_data_o (rf_wr_data),
    .alloc_valid_i(alloc_valid),
    .alloc_rd_i   (alloc_rd),
    .query_rs1_i  (query_rs1),
    .query_rs2_i  (query_rs2),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
    .idle_o       (idle)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_last    = 2;
    m_wr_en   = 1'b0;
    m_wr_addr = 5'd0;
    m_wr_data = 32'd0;
    last_g    = 3'b000;
  endtask

  // Winner = first valid source in priority order; order rotates after the last winner in RR mode.
  function automatic logic [2:0] exp_grant();
    logic [2:0] g;
    int s;
    g = 3'b000;
    if (reset_n && !wb_stall) begin
      for (int k = 1; k <= 3; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        s = (m_last + k) % 3;
`else
        s = (k == 1) ? 1 : (k == 2) ? 2 : 0;
`endif
        if (g == 3'b000 && src_valid[s]) g[s] = 1'b1;
      end
    end
    return g;
  endfunction

  // Called at posedge+1 after inputs are applied; returns at the next posedge+1.
  task automatic cycle();
    logic [2:0] g;
    bit any_busy;
    #1;
    g = exp_grant();
    chk("src_ready", 32'(src_ready), 32'(g));
    chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[query_rs1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[query_rs2]));
    if (reset_n) begin
      m_wr_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (g[k]) begin
          m_last = k;
          m_busy[src_rd[k]] = 1'b0;
          if (src_rd[k] != 5'd0) begin
            m_wr_en   = 1'b1;
            m_wr_addr = src_rd[k];
            m_wr_data = src_data[k];
          end
        end
      end
      if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    #1;
    any_busy = 1'b0;
    foreach (m_busy[r]) if (m_busy[r]) any_busy = 1'b1;
    chk("rf_wr_en", 32'(rf_wr_en), 32'(m_wr_en));
    chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_wr_addr));
    chk("rf_wr_data", rf_wr_data, m_wr_data);
    chk("idle", 32'(idle), 32'(!any_busy && !m_wr_en));
  endtask

  // Retire remaining requests one grant at a time so waiting sources never drop early.
  task automatic drain();
    int n;
    n = 0;
    src_valid = src_valid & ~last_g;
    while (src_valid != 3'b000 && n < 10) begin
      cycle();
      src_valid = src_valid & ~last_g;
      n++;
    end
    if (src_valid != 3'b000) begin
      checks++;
      errors++;
      $error("FAIL drain: pending valids %b after %0d cycles, expected 000", src_valid, n);
      src_valid = 3'b000;
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    src_valid   = 3'b000;
    src_rd      = '0;
    src_data    = '0;
    wb_stall    = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = 5'd0;
    query_rs1   = 5'd0;
    query_rs2   = 5'd0;
    m_reset();
    @(posedge clk);
    #1;

    // Reset: ready gated even with valids up; outputs at reset values.
    src_valid = 3'b111;
    src_rd    = {5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) src_valid = 3'b000;
      #1;
      chk("rst_ready", 32'(src_ready), 32'h0);
      chk("rst_wr_en", 32'(rf_wr_en), 32'h0);
      chk("rst_wr_addr", 32'(rf_wr_addr), 32'h0);
      chk("rst_wr_data", rf_wr_data, 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
      cycle();
    end
    reset_n = 1'b1;

    // Allocate rd=5, then ALU write-back to rd=5.
    alloc_valid = 1'b1;
    alloc_rd    = 5'd5;
    query_rs1   = 5'd5;
    cycle();
    alloc_valid  = 1'b0;
    src_valid    = 3'b001;
    src_rd[0]    = 5'd5;
    src_data[0]  = 32'h1234;
    #1;
    chk("alu_ready", 32'(src_ready), 32'h1);
    chk("rd5_busy_before", 32'(rs1_busy), 32'h1);
    chk("alu_idle_busy", 32'(idle), 32'h0);
    cycle();
    chk("alu_wr_en", 32'(rf_wr_en), 32'h1);
    chk("alu_wr_addr", 32'(rf_wr_addr), 32'h5);
    chk("alu_wr_data", rf_wr_data, 32'h1234);
    src_valid = 3'b000;
    #1;
    chk("rd5_busy_after", 32'(rs1_busy), 32'h0);
    cycle();
    chk("wr_en_pulse", 32'(rf_wr_en), 32'h0);

    // Fresh reset so arbitration starts from the reset pointer.
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst2_wr_en", 32'(rf_wr_en), 32'h0);
    cycle();
    reset_n = 1'b1;

    // All three sources contend for six cycles.
    src_valid = 3'b111;
    src_rd    = {5'd3, 5'd2, 5'd1};
    src_data  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001};
    for (int i = 0; i < 6; i++) begin
      logic [2:0] exp_g;
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_g = 3'b001 << (i % 3);
`else
      exp_g = 3'b010;
`endif
      #1;
      chk("contend_grant", 32'(src_ready), 32'(exp_g));
      cycle();
    end
    drain();

    // Stall with LSU pending: nothing granted until release.
    src_valid   = 3'b010;
    src_rd[1]   = 5'd4;
    src_data[1] = 32'hCAFE_F00D;
    wb_stall    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", 32'(src_ready), 32'h0);
      cycle();
      chk("stall_wr_en", 32'(rf_wr_en), 32'h0);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready", 32'(src_ready), 32'h2);
    cycle();
    chk("unstall_wr_en", 32'(rf_wr_en), 32'h1);
    chk("unstall_wr_addr", 32'(rf_wr_addr), 32'h4);
    chk("unstall_wr_data", rf_wr_data, 32'hCAFE_F00D);
    drain();

    // Same-edge allocate and write-back of rd=7; then a write-back to rd=0.
    alloc_valid = 1'b1;
    alloc_rd    = 5'd7;
    cycle();
    src_valid   = 3'b001;
    src_rd[0]   = 5'd7;
    src_data[0] = 32'h0000_7777;
    cycle();
    alloc_valid = 1'b0;
    src_valid   = 3'b000;
    query_rs1   = 5'd7;
    #1;
    chk("rd7_set_wins", 32'(rs1_busy), 32'h1);
    cycle();
    src_valid   = 3'b001;
    src_rd[0]   = 5'd0;
    src_data[0] = 32'h5555_5555;
    query_rs2   = 5'd0;
    #1;
    chk("rd0_ready", 32'(src_ready), 32'h1);
    chk("rd0_busy", 32'(rs2_busy), 32'h0);
    cycle();
    chk("rd0_no_write", 32'(rf_wr_en), 32'h0);
    src_valid = 3'b000;
    cycle();

    // Reset lands mid-cycle right after a handshake.
    src_valid   = 3'b001;
    src_rd[0]   = 5'd9;
    src_data[0] = 32'h0000_BEEF;
    cycle();
    chk("pre_rst_wr_en", 32'(rf_wr_en), 32'h1);
    src_valid = 3'b000;
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_wr_en", 32'(rf_wr_en), 32'h0);
    chk("async_rst_wr_addr", 32'(rf_wr_addr), 32'h0);
    chk("async_rst_idle", 32'(idle), 32'h1);
    @(posedge clk);
    #1;
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_no_pulse", 32'(rf_wr_en), 32'h0);
    end

    // Random traffic; a source only changes its request after being granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!src_valid[i] || last_g[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            src_valid[i] = 1'b1;
            src_rd[i]    = 5'($urandom_range(0, 31));
            src_data[i]  = $urandom;
          end else begin
            src_valid[i] = 1'b0;
          end
        end
      end
      wb_stall    = ($urandom_range(0, 4) == 0);
      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_rd    = 5'($urandom_range(0, 31));
      query_rs1   = 5'($urandom_range(0, 31));
      query_rs2   = 5'($urandom_range(0, 31));
      cycle();
    end
    wb_stall    = 1'b0;
    alloc_valid = 1'b0;
    drain();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
